// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and ID-side resolution bundle for the branch predictor.
// master = datapath (drives PCs/updates), slave = predictor (drives prediction).
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            pred_btb_hit;
  logic            pred_valid;
  logic [XLEN-1:0] pred_target;
  logic            upd_en;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispredict;

  modport master (
    output pred_pc, upd_en, upd_pc,
    output upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_btb_hit,
    input  pred_valid, pred_target
  );

  modport slave (
    input  pred_pc, upd_en, upd_pc,
    input  upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_btb_hit,
    output pred_valid, pred_target
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: counter BHT (bimodal/gshare) + tagged direct-mapped BTB.
// Ports: clk, start_n (async low reset), bp (slave bundle), ghr, stat_updates, stat_mispredicts.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX   = 5,
  parameter int BTB_IDX   = 5,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 0,
  parameter int STAT_W    = 32
) (
  input  logic                 clk,
  input  logic                 start_n,
  branch_predict_unit_if.slave bp,
  output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] ghr,
  output logic [STAT_W-1:0]    stat_updates,
  output logic [STAT_W-1:0]    stat_mispredicts
);

  localparam int GW    = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam int BHT_N = 1 << BHT_IDX;
  localparam int BTB_N = 1 << BTB_IDX;
  localparam int TAG_W = XLEN - BTB_IDX - 2;

  typedef logic [BHT_IDX-1:0]  bhi_t;
  typedef logic [BTB_IDX-1:0]  bti_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [CTR_BITS-1:0] ctr_t;
  typedef logic [GW-1:0]       ghr_t;
  typedef logic [STAT_W-1:0]   stat_t;

  localparam ctr_t CTR_INIT = ctr_t'((1 << (CTR_BITS - 1)) - 1);
  localparam ctr_t CTR_MAX  = '1;

  ctr_t        bht_q [BHT_N];
  logic        vld_q [BTB_N];
  tag_t        tag_q [BTB_N];
  logic [XLEN-1:0] tgt_q [BTB_N];
  ghr_t        ghr_q, ghr_d;
  stat_t       upd_cnt_q, upd_cnt_d;
  stat_t       mis_cnt_q, mis_cnt_d;
  ctr_t        ctr_cur, ctr_d;

  bhi_t p_bi, u_bi;
  bti_t p_ti, u_ti;
  tag_t p_tag, u_tag;
  logic p_hit;

  logic unused;
  assign unused = ^{bp.pred_pc[1:0], bp.upd_pc[1:0]};

  // Lookup: pure combinational read of current state, no update bypass.
  always_comb begin
    p_bi  = bhi_t'(bp.pred_pc[BHT_IDX+1:2]) ^ bhi_t'(ghr_q);
    p_ti  = bp.pred_pc[BTB_IDX+1:2];
    p_tag = bp.pred_pc[XLEN-1:BTB_IDX+2];
    p_hit = vld_q[p_ti] && (tag_q[p_ti] == p_tag);
  end

  assign bp.pred_taken   = bht_q[p_bi][CTR_BITS-1];
  assign bp.pred_btb_hit = p_hit;
  assign bp.pred_valid   = bp.pred_taken && p_hit;
  assign bp.pred_target  = p_hit ? tgt_q[p_ti] : '0;

  always_comb begin
    u_bi    = bhi_t'(bp.upd_pc[BHT_IDX+1:2]) ^ bhi_t'(ghr_q);
    u_ti    = bp.upd_pc[BTB_IDX+1:2];
    u_tag   = bp.upd_pc[XLEN-1:BTB_IDX+2];
    ctr_cur = bht_q[u_bi];
    ctr_d   = ctr_cur;
    if (bp.upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + ctr_t'(1);
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - ctr_t'(1);
    end
    // Truncating cast keeps the newest GW outcomes.
    ghr_d = (HIST_BITS > 0) ? ghr_t'({ghr_q, bp.upd_taken}) : '0;
    upd_cnt_d = upd_cnt_q;
    if (~&upd_cnt_q) upd_cnt_d = upd_cnt_q + stat_t'(1);
    mis_cnt_d = mis_cnt_q;
    if (bp.upd_mispredict && ~&mis_cnt_q)
      mis_cnt_d = mis_cnt_q + stat_t'(1);
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= CTR_INIT;
      for (int i = 0; i < BTB_N; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
      ghr_q     <= '0;
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else if (bp.upd_en) begin
      bht_q[u_bi] <= ctr_d;
      if (bp.upd_taken) begin
        vld_q[u_ti] <= 1'b1;
        tag_q[u_ti] <= u_tag;
        tgt_q[u_ti] <= bp.upd_target;
      end
      ghr_q     <= ghr_d;
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign ghr              = ghr_q;
  assign stat_updates     = upd_cnt_q;
  assign stat_mispredicts = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench for branch_predict_unit.
// u0: bimodal defaults; u1: gshare HIST_BITS=2, STAT_W=4.
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic start_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32)) bi0 ();
  branch_predict_unit_if #(.XLEN(32)) bi1 ();

  logic        ghr0;
  logic [1:0]  ghr1;
  logic [31:0] su0, sm0;
  logic [3:0]  su1, sm1;

  branch_predict_unit u0 (
    .clk(clk), .start_n(start_n), .bp(bi0),
    .ghr(ghr0), .stat_updates(su0), .stat_mispredicts(sm0)
  );

  branch_predict_unit #(.HIST_BITS(2), .STAT_W(4)) u1 (
    .clk(clk), .start_n(start_n), .bp(bi1),
    .ghr(ghr1), .stat_updates(su1), .stat_mispredicts(sm1)
  );

  typedef struct {
    string       tag;
    logic        tk;
    logic        hit;
    logic        vld;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_u = 0;
  int n_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input int d, input string tag, input logic [31:0] pc,
                      input logic tk, input logic hit, input logic [31:0] tgt);
    exp_t e;
    logic [63:0] o;
    if (d == 0) bi0.pred_pc = pc;
    else        bi1.pred_pc = pc;
    sb.push_back('{tag, tk, hit, tk & hit, tgt});
    #1;
    e = sb.pop_front();
    if (d == 0)
      o = {29'd0, bi0.pred_taken, bi0.pred_btb_hit, bi0.pred_valid, bi0.pred_target};
    else
      o = {29'd0, bi1.pred_taken, bi1.pred_btb_hit, bi1.pred_valid, bi1.pred_target};
    chk(e.tag, o, {29'd0, e.tk, e.hit, e.vld, e.tgt});
  endtask

  task automatic drive(input int d, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg, input logic m);
    if (d == 0) begin
      bi0.upd_en = 1'b1; bi0.upd_pc = pc; bi0.upd_taken = tk;
      bi0.upd_target = tg; bi0.upd_mispredict = m;
      n_u++;
      n_m += int'(m);
    end else begin
      bi1.upd_en = 1'b1; bi1.upd_pc = pc; bi1.upd_taken = tk;
      bi1.upd_target = tg; bi1.upd_mispredict = m;
    end
  endtask

  task automatic upd(input int d, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg, input logic m);
    @(negedge clk);
    drive(d, pc, tk, tg, m);
    @(negedge clk);
    bi0.upd_en = 1'b0;
    bi1.upd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bi0.pred_pc = '0; bi0.upd_en = 0; bi0.upd_pc = '0;
    bi0.upd_taken = 0; bi0.upd_target = '0; bi0.upd_mispredict = 0;
    bi1.pred_pc = '0; bi1.upd_en = 0; bi1.upd_pc = '0;
    bi1.upd_taken = 0; bi1.upd_target = '0; bi1.upd_mispredict = 0;

    #12;
    look(0, "rst_look", 32'h40, 0, 0, 32'h0);
    chk("rst_su", 64'(su0), 64'd0);
    chk("rst_sm", 64'(sm0), 64'd0);
    chk("rst_ghr1", 64'(ghr1), 64'd0);
    @(negedge clk);
    start_n = 1'b1;

    upd(0, 32'h40, 1, 32'h100, 0);
    look(0, "first_upd", 32'h40, 1, 1, 32'h100);
    chk("su_one", 64'(su0), 64'd1);

    for (int i = 0; i < 4; i++) upd(0, 32'h40, 1, 32'h100, i[0]);
    upd(0, 32'h40, 0, 32'h0, 1);
    look(0, "sat_hi_nt1", 32'h40, 1, 1, 32'h100);
    upd(0, 32'h40, 0, 32'h0, 0);
    upd(0, 32'h40, 0, 32'h0, 0);
    look(0, "sat_nt3", 32'h40, 0, 1, 32'h100);
    upd(0, 32'h40, 0, 32'h0, 0);
    look(0, "sat_lo", 32'h40, 0, 1, 32'h100);
    upd(0, 32'h40, 1, 32'h100, 0);
    look(0, "sat_lo_t1", 32'h40, 0, 1, 32'h100);
    upd(0, 32'h40, 1, 32'h100, 0);
    look(0, "sat_lo_t2", 32'h40, 1, 1, 32'h100);

    look(0, "alias_miss", 32'hC0, 1, 0, 32'h0);
    upd(0, 32'hC0, 1, 32'h200, 1);
    look(0, "alias_new", 32'hC0, 1, 1, 32'h200);
    look(0, "alias_old", 32'h40, 1, 0, 32'h0);

    upd(0, 32'h80, 1, 32'h300, 0);
    upd(0, 32'h80, 0, 32'h0, 0);
    look(0, "nt_keep1", 32'h80, 0, 1, 32'h300);
    upd(0, 32'h80, 0, 32'h0, 0);
    look(0, "nt_keep2", 32'h80, 0, 1, 32'h300);
    look(0, "low_bits", 32'h83, 0, 1, 32'h300);

    @(negedge clk);
    drive(0, 32'h104, 1, 32'h500, 0);
    look(0, "same_cyc_pre", 32'h104, 0, 0, 32'h0);
    @(negedge clk);
    bi0.upd_en = 1'b0;
    look(0, "same_cyc_post", 32'h104, 1, 1, 32'h500);
    chk("su_total", 64'(su0), 64'(n_u));
    chk("sm_total", 64'(sm0), 64'(n_m));
    chk("ghr0_zero", 64'(ghr0), 64'd0);

    upd(1, 32'h48, 1, 32'h300, 1);
    upd(1, 32'h0, 0, 32'h0, 1);
    chk("ghr_10", 64'(ghr1), 64'd2);
    look(1, "gshare_idx", 32'h40, 1, 0, 32'h0);
    look(1, "gshare_48", 32'h48, 0, 1, 32'h300);

    for (int i = 0; i < 18; i++) upd(1, 32'h48, 1, 32'h300, 1);
    chk("su_sat", 64'(su1), 64'hF);
    chk("sm_sat", 64'(sm1), 64'hF);
    chk("ghr_11", 64'(ghr1), 64'd3);
    look(1, "gshare_hot", 32'h48, 1, 1, 32'h300);

    @(negedge clk);
    drive(1, 32'h48, 1, 32'h300, 1);
    #1;
    start_n = 1'b0;
    #1;
    chk("arst_su", 64'(su1), 64'd0);
    chk("arst_sm", 64'(sm1), 64'd0);
    chk("arst_ghr", 64'(ghr1), 64'd0);
    look(1, "arst_btb", 32'h48, 0, 0, 32'h0);
    look(0, "arst_btb0", 32'h40, 0, 0, 32'h0);
    @(negedge clk);
    chk("arst_drop", 64'(su1), 64'd0);
    bi1.upd_en = 1'b0;
    start_n = 1'b1;
    @(negedge clk);
    chk("post_rst_su", 64'(su1), 64'd0);
    look(1, "post_rst_look", 32'h48, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised dynamic branch prediction unit that replaces the separate fixed-size BHT/BTB pair.
- Combinational lookup from fetch PC: direction, target and hit.
- Registered update from ID-stage branch resolution.
- Configurable table depths, counter width and optional gshare global-history indexing.
- Tagged BTB and saturating prediction/mispredict statistics counters.
- Sits beside PC generation in the datapath IF stage.

Parameters:
XLEN, 32, address width.
BHT_IDX, 5, log2 BHT entries (index from pc[BHT_IDX+1:2]).
BTB_IDX, 5, log2 BTB entries (index from pc[BTB_IDX+1:2]).
CTR_BITS, 2, saturating counter width (1..3).
HIST_BITS, 0, global history length; 0 = bimodal; must be <= BHT_IDX.
STAT_W, 32, statistics counter width.

Ports:
clk  in  1  clock, all state updates on rising edge.
start_n  in  1  asynchronous active-low reset.
pred_pc  in  XLEN  fetch PC to predict.
pred_taken  out  1  BHT counter MSB for pred_pc.
pred_btb_hit  out  1  BTB entry for pred_pc is valid and tag matches.
pred_valid  out  1  pred_taken && pred_btb_hit; PC mux selects pred_target when set.
pred_target  out  XLEN  BTB target (0 when no hit).
upd_en  in  1  one resolved branch/jump this cycle.
upd_pc  in  XLEN  PC of resolved instruction.
upd_taken  in  1  resolved direction.
upd_target  in  XLEN  resolved target.
upd_mispredict  in  1  fetch-time prediction was wrong (from datapath compare).
ghr  out  max(HIST_BITS,1)  current global history (0 when HIST_BITS=0).
stat_updates  out  STAT_W  count of upd_en cycles.
stat_mispredicts  out  STAT_W  count of upd_en && upd_mispredict cycles.

Behaviour:
- Reset (start_n low, asynchronous, takes effect immediately):
  - Every BHT counter = 2^(CTR_BITS-1)-1 (weakly not-taken).
  - Every BTB valid = 0; ghr = 0; both stats = 0.
  - Outputs derive from cleared state: pred_taken=0, pred_btb_hit=0, pred_valid=0, pred_target=0.
  - Reset mid-update discards the pending update.
- Lookup is purely combinational, zero latency.
  - BHT index = pred_pc[BHT_IDX+1:2] XOR zero-extended ghr.
  - BTB index = pred_pc[BTB_IDX+1:2]; tag = pred_pc[XLEN-1:BTB_IDX+2].
- Update on rising clk when upd_en=1. Indexing is identical, using upd_pc and the pre-edge ghr.
  - Counter: +1 if upd_taken, saturating at 2^CTR_BITS-1; -1 if not, saturating at 0.
  - BTB: if upd_taken, write valid=1, tag and upd_target, overwriting any alias (direct-mapped replace). If not taken, the BTB entry is unchanged.
  - ghr (HIST_BITS>0): shifts left, inserting upd_taken at bit 0, truncated to HIST_BITS. Non-speculative.
  - stat_updates += 1; stat_mispredicts += upd_mispredict. Both saturate at all-ones, no wrap.
- upd_en=0: no state change.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value, no bypass. The new value is visible from the next cycle.
- Low 2 PC bits are ignored for indexing and tags.
- No stall input. The datapath must hold upd_en low while the ID stage is stalled so each branch updates exactly once.

Test Plan:
- Reset, pred_pc=0x40 -> pred_taken=0, pred_btb_hit=0, pred_valid=0, pred_target=0, stats=0.
- One update: upd_pc=0x40, taken, target=0x100 -> next cycle pred_pc=0x40 gives counter 2'b10, pred_taken=1, pred_btb_hit=1, pred_valid=1, pred_target=0x100, stat_updates=1.
- Saturation: 4 taken updates at 0x40 (counter 3), then 1 not-taken -> pred_taken=1; 2 more not-taken -> pred_taken=0, counter 0; a further not-taken leaves 0. BTB still hits with target 0x100.
- Tag alias:
  - After the 0x40 entry is installed, lookup 0xC0 (same index 16) -> pred_btb_hit=0.
  - Update 0xC0 taken, target 0x200 -> 0xC0 hits with 0x200; 0x40 now misses.
  - Not-taken update at 0x80 leaves the BTB valid bit for index 0 unchanged.
- gshare, HIST_BITS=2: updates taken, not-taken -> ghr=2'b10. Lookup 0x40 uses BHT index 16^2=18; an update at 0x48 (index 18, ghr=0) is observed on that lookup.
- Stats with STAT_W=4: 20 updates with upd_mispredict=1 -> both counters hold 4'hF. Pulse start_n low mid-burst -> counters, ghr and BTB valids read 0 before the next clk edge.
